// File: rtl/synapse_matrix_array_pkg.sv
// Shared neuron-core definitions: synapse store FSM states, word width and
// the flat word-address helper used to index axon rows.
package synapse_matrix_array_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WB_RD,
        ST_WB_ACK,
        ST_CORE_RD,
        ST_CORE_LAST
    } sma_state_e;

    // Row-major layout: every axon owns `words` consecutive memory words.
    function automatic logic [31:0] flat_word_addr(input logic [31:0] axon,
                                                   input logic [31:0] word,
                                                   input logic [31:0] words);
        return axon * words + word;
    endfunction

endpackage

// File: rtl/synapse_matrix_array_if.sv
// Wishbone classic slave bundle for the synapse store (host programming port).
interface synapse_matrix_array_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/synapse_matrix_array_mem.sv
// Single-port 32-bit synapse memory, 1-cycle registered read, byte write enables.
// Port shape matches the DFFRAM macro so the 256-word configuration can swap it in.
module synapse_mem_sp
    import synapse_matrix_array_pkg::*;
#(
    parameter int AW    = 9,
    parameter int DEPTH = 512
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/synapse_matrix_array.sv
// Synapse crossbar store: clears its memory after reset, then arbitrates host
// Wishbone accesses against full-row lookups from the neuron core.
module synapse_matrix_array
    import synapse_matrix_array_pkg::*;
#(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 64
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    synapse_matrix_array_if.slave        wb,
    input  logic                         core_req_i,
    input  logic [$clog2(NUM_AXONS)-1:0] core_axon_i,
    output logic                         core_ready_o,
    output logic                         core_valid_o,
    output logic [NUM_NEURONS-1:0]       neurons_connections_o,
    output logic                         init_done_o
);

    localparam int WORDS = NUM_NEURONS / WORD_BITS;
    localparam int AW    = $clog2(NUM_AXONS * WORDS);
    localparam int XW    = $clog2(NUM_AXONS);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    sma_state_e           state_q, state_d;
    logic [AW:0]          clr_addr_q;
    logic [XW-1:0]        axon_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_NEURONS-1:0] row_q, row_full;

    logic                 wb_grant;
    logic [3:0]           mem_we, mem_we_gated;
    logic [AW-1:0]        mem_addr;
    logic [WORD_BITS-1:0] mem_wdata, mem_rdata;
    logic [31:0]          core_addr_full;
    logic                 unused_bits;

    assign wb_grant       = (state_q == ST_IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i && !wb.wbs_ack_o;
    assign core_ready_o   = init_done_o && (state_q == ST_IDLE) && !wb_grant;
    assign core_addr_full = flat_word_addr(32'(axon_q), 32'(cnt_q), 32'(WORDS));
    assign mem_we_gated   = wb_rst_i ? 4'h0 : mem_we;
    assign unused_bits    = ^{wb.wbs_adr_i[31:AW+2], wb.wbs_adr_i[1:0], core_addr_full[31:AW]};

    synapse_mem_sp #(
        .AW    (AW),
        .DEPTH (NUM_AXONS * WORDS)
    ) u_mem (
        .clk   (wb_clk_i),
        .we    (mem_we_gated),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // The last slice is never latched into row_q; it is merged straight from the memory output.
    always_comb begin
        row_full = row_q;
        row_full[NUM_NEURONS-1 -: WORD_BITS] = mem_rdata;
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 4'h0;
        mem_addr  = wb.wbs_adr_i[AW+1:2];
        mem_wdata = wb.wbs_dat_i;
        case (state_q)
            ST_INIT: begin
                mem_addr  = clr_addr_q[AW-1:0];
                mem_wdata = '0;
                if (!clr_addr_q[AW]) begin
                    mem_we = 4'hF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (wb_grant) begin
                    if (wb.wbs_we_i) begin
                        mem_we  = wb.wbs_sel_i;
                        state_d = ST_WB_ACK;
                    end else begin
                        state_d = ST_WB_RD;
                    end
                end else if (core_req_i && core_ready_o) begin
                    state_d = ST_CORE_RD;
                end
            end
            ST_WB_RD:  state_d = ST_WB_ACK;
            ST_WB_ACK: state_d = ST_IDLE;
            ST_CORE_RD: begin
                mem_addr = core_addr_full[AW-1:0];
                if (cnt_q == CW'(WORDS - 1)) begin
                    state_d = ST_CORE_LAST;
                end
            end
            ST_CORE_LAST: state_d = ST_IDLE;
            default:      state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q               <= ST_INIT;
            clr_addr_q            <= '0;
            init_done_o           <= 1'b0;
            wb.wbs_ack_o          <= 1'b0;
            wb.wbs_dat_o          <= '0;
            core_valid_o          <= 1'b0;
            neurons_connections_o <= '0;
            axon_q                <= '0;
            cnt_q                 <= '0;
            row_q                 <= '0;
        end else begin
            state_q      <= state_d;
            wb.wbs_ack_o <= (state_d == ST_WB_ACK);
            core_valid_o <= (state_q == ST_CORE_LAST);
            case (state_q)
                ST_INIT: begin
                    if (!clr_addr_q[AW]) begin
                        clr_addr_q <= clr_addr_q + (AW+1)'(1);
                    end else begin
                        init_done_o <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (core_req_i && core_ready_o) begin
                        axon_q <= core_axon_i;
                        cnt_q  <= '0;
                    end
                end
                ST_WB_RD: wb.wbs_dat_o <= mem_rdata;
                ST_CORE_RD: begin
                    // Data now on the memory output belongs to the word issued last cycle.
                    if (cnt_q != '0) begin
                        row_q[WORD_BITS*(int'(cnt_q) - 1) +: WORD_BITS] <= mem_rdata;
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
                ST_CORE_LAST: neurons_connections_o <= row_full;
                default: ;
            endcase
        end
    end

endmodule
